// File: rtl/clk_divider_multi.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Optional CLK_DIVIDER_SYNC_EN adds a `sync` input that phase-aligns every channel.
module clk_divider_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 24,
    parameter int DEFAULT_HALF = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CLK_DIVIDER_SYNC_EN
    input  logic                 sync,
`endif
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [CNT_WIDTH-1:0] wr_half,
    output logic [NUM_CH-1:0]    pending,
    output logic [NUM_CH-1:0]    clk_divided,
    output logic [NUM_CH-1:0]    tick
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] HALF_DEF = CNT_WIDTH'(DEFAULT_HALF);

    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] half_q [NUM_CH];
    logic [CNT_WIDTH-1:0] half_d [NUM_CH];
    logic [CNT_WIDTH-1:0] pval_q [NUM_CH];
    logic [CNT_WIDTH-1:0] pval_d [NUM_CH];
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [NUM_CH-1:0]    clk_q, clk_d;
    logic [NUM_CH-1:0]    tick_q, tick_d;
    logic [NUM_CH-1:0]    wr_hit_s;
    logic                 wr_ok_s;
    logic                 sync_s;

`ifdef CLK_DIVIDER_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Write decode: out-of-range channel indices are dropped.
    always_comb begin
        wr_ok_s = ({{(32-CH_W){1'b0}}, wr_ch} < 32'(NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit_s[i] = wr_en & wr_ok_s & (wr_ch == CH_W'(i));
        end
    end

    // Per-channel next state; a pending divisor only lands on an interval boundary.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            half_d[i] = half_q[i];
            pval_d[i] = pval_q[i];
            pend_d[i] = pend_q[i];
            clk_d[i]  = clk_q[i];
            tick_d[i] = 1'b0;
            if (sync_s) begin
                if (pend_q[i]) begin
                    half_d[i] = pval_q[i];
                end else begin
                    half_d[i] = half_q[i];
                end
                pend_d[i] = 1'b0;
                cnt_d[i]  = CNT_ZERO;
                clk_d[i]  = 1'b0;
            end else if (half_q[i] == CNT_ZERO) begin
                cnt_d[i] = CNT_ZERO;
                clk_d[i] = 1'b0;
                if (pend_q[i]) begin
                    half_d[i] = pval_q[i];
                    pend_d[i] = 1'b0;
                end else begin
                    half_d[i] = half_q[i];
                end
            end else if (cnt_q[i] == (half_q[i] - CNT_ONE)) begin
                cnt_d[i] = CNT_ZERO;
                if (pend_q[i] && (pval_q[i] == CNT_ZERO)) begin
                    half_d[i] = CNT_ZERO;
                    pend_d[i] = 1'b0;
                    clk_d[i]  = 1'b0;
                end else begin
                    if (pend_q[i]) begin
                        half_d[i] = pval_q[i];
                        pend_d[i] = 1'b0;
                    end else begin
                        half_d[i] = half_q[i];
                    end
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            // A same-cycle write always becomes the next pending value.
            if (wr_hit_s[i]) begin
                pval_d[i] = wr_half;
                pend_d[i] = 1'b1;
            end else begin
                pval_d[i] = pval_d[i];
            end
        end
    end

    // State registers with synchronous reset that overrides any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= CNT_ZERO;
                half_q[i] <= HALF_DEF;
                pval_q[i] <= CNT_ZERO;
            end
            pend_q <= {NUM_CH{1'b0}};
            clk_q  <= {NUM_CH{1'b0}};
            tick_q <= {NUM_CH{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign pending     = pend_q;
    assign clk_divided = clk_q;
    assign tick        = tick_q;

endmodule
